// File: rtl/opcode_fetch.sv
// CHIP-8 instruction fetch: reads a big-endian 16-bit opcode as two bytes from
// byte-wide program RAM and offers it to execute with a valid/ready handshake.
module opcode_fetch #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(12'h200)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       opcode,
  output logic              opcode_valid,
  input  logic              opcode_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  input  logic              skip
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    CAPT_LO = 3'd3,
    VALID   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] pc_nxt;
  logic              accept;

  assign accept = (state == VALID) && opcode_ready;

  // Next-state and RAM strobe decode; the RAM answers one cycle after each read.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = pc;
    case (state)
      IDLE:    state_nxt = ADDR_HI;
      ADDR_HI: begin
        mem_rd    = 1'b1;
        state_nxt = ADDR_LO;
      end
      ADDR_LO: begin
        mem_rd    = 1'b1;
        mem_addr  = pc + ADDR_W'(1);
        state_nxt = CAPT_LO;
      end
      CAPT_LO: state_nxt = VALID;
      VALID:   if (opcode_ready) state_nxt = ADDR_HI;
      default: state_nxt = IDLE;
    endcase
  end

  // Steering inputs only matter in the accept cycle; load beats skip.
  always_comb begin
    pc_nxt = pc;
    if (accept) begin
      if (pc_load)   pc_nxt = pc_load_value;
      else if (skip) pc_nxt = pc + ADDR_W'(4);
      else           pc_nxt = pc + ADDR_W'(2);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pc           <= PC_RESET;
      hi_byte      <= 8'h00;
      opcode       <= 16'h0000;
      opcode_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == ADDR_LO) hi_byte <= mem_rdata;
      if (state == CAPT_LO) begin
        opcode       <= {hi_byte, mem_rdata};
        opcode_valid <= 1'b1;
      end else if (accept) begin
        opcode_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opcode_fetch.sv
// Directed and randomized checks of opcode_fetch against a byte RAM model.
module tb_opcode_fetch;

  logic        clk;
  logic        reset_n;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [15:0] opcode;
  logic        opcode_valid;
  logic        opcode_ready;
  logic [11:0] pc;
  logic        pc_load;
  logic [11:0] pc_load_value;
  logic        skip;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [0:4095];

  opcode_fetch #(.ADDR_W(12), .PC_RESET(12'h200)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .opcode       (opcode),
    .opcode_valid (opcode_valid),
    .opcode_ready (opcode_ready),
    .pc           (pc),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .skip         (skip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears one cycle after a strobed read.
  always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

  // Bounded wait for opcode_valid, sampled on falling edges.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!opcode_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!opcode_valid) begin
      errors++;
      $display("FAIL %s timeout: opcode_valid=%b required 1", name, opcode_valid);
    end
  endtask

  task automatic accept_once(input logic ld, input logic [11:0] ldv, input logic sk);
    opcode_ready = 1'b1; pc_load = ld; pc_load_value = ldv; skip = sk;
    @(negedge clk);
    opcode_ready = 1'b0; pc_load = 1'b0; pc_load_value = 12'h000; skip = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pc !== 12'h200 || opcode_valid !== 1'b0 || mem_rd !== 1'b0 ||
        mem_addr !== 12'h200 || opcode !== 16'h0000) begin
      errors++;
      $display("FAIL reset: pc=%h v=%b rd=%b addr=%h op=%h required 200/0/0/200/0000",
               pc, opcode_valid, mem_rd, mem_addr, opcode);
    end
  endtask

  task automatic test_first_fetch;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 12'h200 || opcode_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_hi: rd=%b addr=%h v=%b required 1/200/0", mem_rd, mem_addr, opcode_valid);
    end
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 12'h201 || opcode_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_lo: rd=%b addr=%h v=%b required 1/201/0", mem_rd, mem_addr, opcode_valid);
    end
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0 || opcode_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_capt: rd=%b v=%b required 0/0", mem_rd, opcode_valid);
    end
    @(negedge clk);
    checks++;
    if (opcode_valid !== 1'b1 || opcode !== 16'h1234 || pc !== 12'h200) begin
      errors++;
      $display("FAIL first_valid: v=%b op=%h pc=%h required 1/1234/200", opcode_valid, opcode, pc);
    end
    accept_once(1'b0, 12'h000, 1'b0);
    checks++;
    if (opcode_valid !== 1'b0 || pc !== 12'h202 || mem_rd !== 1'b1 || mem_addr !== 12'h202) begin
      errors++;
      $display("FAIL seq_next: v=%b pc=%h rd=%b addr=%h required 0/202/1/202",
               opcode_valid, pc, mem_rd, mem_addr);
    end
  endtask

  task automatic test_stall;
    int n;
    wait_valid("stall_wait", n);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (opcode !== 16'h00E0 || pc !== 12'h202 || mem_rd !== 1'b0 || opcode_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: op=%h pc=%h rd=%b v=%b required 00E0/202/0/1",
                 i, opcode, pc, mem_rd, opcode_valid);
      end
      @(negedge clk);
    end
    accept_once(1'b0, 12'h000, 1'b0);
    checks++;
    if (pc !== 12'h204 || mem_rd !== 1'b1 || mem_addr !== 12'h204) begin
      errors++;
      $display("FAIL stall_resume: pc=%h rd=%b addr=%h required 204/1/204", pc, mem_rd, mem_addr);
    end
  endtask

  task automatic test_skip_load;
    int n;
    wait_valid("skip_wait", n);
    checks++;
    if (opcode !== 16'h3ABC || pc !== 12'h204) begin
      errors++;
      $display("FAIL skip_op: op=%h pc=%h required 3ABC/204", opcode, pc);
    end
    accept_once(1'b0, 12'h000, 1'b1);
    checks++;
    if (pc !== 12'h208 || mem_addr !== 12'h208) begin
      errors++;
      $display("FAIL skip_pc: pc=%h addr=%h required 208/208", pc, mem_addr);
    end
    wait_valid("skip_wait2", n);
    checks++;
    if (opcode !== 16'h1122) begin
      errors++;
      $display("FAIL skip_fetch: op=%h required 1122", opcode);
    end
    accept_once(1'b1, 12'h3A0, 1'b1);
    checks++;
    if (pc !== 12'h3A0) begin
      errors++;
      $display("FAIL load_prio: pc=%h required 3A0", pc);
    end
    wait_valid("load_wait", n);
    checks++;
    if (opcode !== 16'hABCD || pc !== 12'h3A0) begin
      errors++;
      $display("FAIL load_fetch: op=%h pc=%h required ABCD/3A0", opcode, pc);
    end
  endtask

  task automatic test_wrap;
    int n;
    accept_once(1'b1, 12'hFFF, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 12'h000 || pc !== 12'hFFF) begin
      errors++;
      $display("FAIL wrap_addr: rd=%b addr=%h pc=%h required 1/000/FFF", mem_rd, mem_addr, pc);
    end
    wait_valid("wrap_wait", n);
    checks++;
    if (opcode !== 16'hD345 || pc !== 12'hFFF) begin
      errors++;
      $display("FAIL wrap_op: op=%h pc=%h required D345/FFF", opcode, pc);
    end
    accept_once(1'b0, 12'h000, 1'b1);
    checks++;
    if (pc !== 12'h003) begin
      errors++;
      $display("FAIL wrap_skip: pc=%h required 003", pc);
    end
  endtask

  task automatic test_async_reset;
    int n;
    wait_valid("ar_wait", n);
    accept_once(1'b1, 12'h3A0, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (mem_addr !== 12'h3A1 || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL ar_in_lo: addr=%h rd=%b required 3A1/1", mem_addr, mem_rd);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (pc !== 12'h200 || opcode_valid !== 1'b0 || mem_rd !== 1'b0 ||
        mem_addr !== 12'h200 || opcode !== 16'h0000) begin
      errors++;
      $display("FAIL ar_immediate: pc=%h v=%b rd=%b addr=%h op=%h required 200/0/0/200/0000",
               pc, opcode_valid, mem_rd, mem_addr, opcode);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_valid("ar_refetch", n);
    checks++;
    if (n !== 4 || opcode !== 16'h1234 || pc !== 12'h200) begin
      errors++;
      $display("FAIL ar_refetch: cycles=%0d op=%h pc=%h required 4/1234/200", n, opcode, pc);
    end
  endtask

  task automatic test_random;
    logic [11:0] pcm, a1, held_pc;
    logic [15:0] exp_op, held_op;
    logic        prev_hold;
    int          acc, cyc;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[12'h200] = 8'h12;
    ram[12'h201] = 8'h34;
    pcm = 12'h200; acc = 0; cyc = 0; prev_hold = 1'b0;
    held_pc = 12'h000; held_op = 16'h0000;
    while (acc < 1000 && cyc < 20000) begin
      if (opcode_valid) begin
        a1 = pcm + 12'd1;
        exp_op = {ram[pcm], ram[a1]};
        checks++;
        if (opcode !== exp_op || pc !== pcm) begin
          errors++;
          $display("FAIL rand_op[%0d]: op=%h pc=%h required %h/%h", acc, opcode, pc, exp_op, pcm);
        end
        if (prev_hold) begin
          checks++;
          if (opcode !== held_op || pc !== held_pc) begin
            errors++;
            $display("FAIL rand_hold[%0d]: op=%h pc=%h required %h/%h",
                     acc, opcode, pc, held_op, held_pc);
          end
        end
      end
      opcode_ready  = 1'($urandom);
      skip          = 1'($urandom);
      pc_load       = ($urandom_range(0, 7) == 0);
      pc_load_value = 12'($urandom);
      if (opcode_valid && opcode_ready) begin
        acc++;
        pcm = pc_load ? pc_load_value : (skip ? pcm + 12'd4 : pcm + 12'd2);
        prev_hold = 1'b0;
      end else begin
        prev_hold = opcode_valid;
        held_op   = opcode;
        held_pc   = pc;
      end
      @(negedge clk);
      cyc++;
    end
    opcode_ready = 1'b0; skip = 1'b0; pc_load = 1'b0;
    checks++;
    if (acc != 1000) begin
      errors++;
      $display("FAIL rand_accepts: got %0d required 1000", acc);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h200] = 8'h12; ram[12'h201] = 8'h34;
    ram[12'h202] = 8'h00; ram[12'h203] = 8'hE0;
    ram[12'h204] = 8'h3A; ram[12'h205] = 8'hBC;
    ram[12'h206] = 8'h55; ram[12'h207] = 8'h66;
    ram[12'h208] = 8'h11; ram[12'h209] = 8'h22;
    ram[12'h3A0] = 8'hAB; ram[12'h3A1] = 8'hCD;
    ram[12'hFFF] = 8'hD3; ram[12'h000] = 8'h45;
    mem_rdata = 8'h00;
    opcode_ready = 1'b0; pc_load = 1'b0; pc_load_value = 12'h000; skip = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_stall();
    test_skip_load();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
